// File: rtl/bch_key_equation_solver_if.sv
// rtl/bch_key_equation_solver_if.sv - syndrome-in / error-locator-out bundle for the BCH key equation solver
//
// master : syndrome side (drives i_code, i_S1..i_S8, i_odd_valid, i_all_valid; sees results)
// slave  : key equation solver (drives o_lambda0..4, o_deg, o_valid, o_busy, o_fail, o_no_err)
interface bch_key_equation_solver_if #(
    parameter int W = 10
);
    logic [1:0]   i_code;
    logic [W-1:0] i_S1, i_S2, i_S3, i_S4, i_S5, i_S6, i_S7, i_S8;
    logic         i_odd_valid;
    logic         i_all_valid;
    logic [W-1:0] o_lambda0, o_lambda1, o_lambda2, o_lambda3, o_lambda4;
    logic [2:0]   o_deg;
    logic         o_valid;
    logic         o_busy;
    logic         o_fail;
    logic         o_no_err;

    modport master (
        output i_code, i_S1, i_S2, i_S3, i_S4, i_S5, i_S6, i_S7, i_S8,
        output i_odd_valid, i_all_valid,
        input  o_lambda0, o_lambda1, o_lambda2, o_lambda3, o_lambda4,
        input  o_deg, o_valid, o_busy, o_fail, o_no_err
    );

    modport slave (
        input  i_code, i_S1, i_S2, i_S3, i_S4, i_S5, i_S6, i_S7, i_S8,
        input  i_odd_valid, i_all_valid,
        output o_lambda0, o_lambda1, o_lambda2, o_lambda3, o_lambda4,
        output o_deg, o_valid, o_busy, o_fail, o_no_err
    );
endinterface

// File: rtl/bch_key_equation_solver.sv
// rtl/bch_key_equation_solver.sv - inversionless Berlekamp-Massey key equation solver for binary BCH
//
// Computes the error-locator Lambda(x) (scaled, not monic), its BM length and status flags
// from syndromes S1..S8 for BCH(63,51) t=2, BCH(255,239) t=2 and BCH(1023,983) t=4.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous reset, active-low
//   kes      slave side of bch_key_equation_solver_if:
//            i_code, i_S1..i_S8, i_odd_valid, i_all_valid in;
//            o_lambda0..4, o_deg, o_valid (1-cycle pulse), o_busy, o_fail, o_no_err out
// Option macro KES_EARLY_START_EN: start on i_odd_valid, capture odd syndromes only and
// derive the even ones by squaring during LOAD.
module bch_key_equation_solver #(
    parameter int W     = 10,
    parameter int T_MAX = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    bch_key_equation_solver_if.slave  kes
);
    typedef enum logic [2:0] {IDLE, LOAD, DISC, UPD, DONE} state_t;

    state_t       state;
    logic         trig_q, trig_q2;
    logic [1:0]   code_q;
    logic [W-1:0] s   [0:7];          // s[k] holds S(k+1)
    logic [W-1:0] lam [0:T_MAX];
    logic [W-1:0] b   [0:T_MAX];
    logic [W-1:0] gamma, delta;
    logic [2:0]   l_q, r_q;
    logic [2:0]   t_q;
    logic         trig, start;

    // GF(2^m) multiply, MSB-first shift-and-add; operands have bits [W-1:m] clear,
    // so reducing at bit m keeps the result inside the field.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] bb,
                                            input logic [1:0] code);
        logic [W:0] p;
        logic [W:0] poly;
        logic [3:0] m;
        case (code)
            2'b00:   begin poly = (W+1)'(11'h043); m = 4'd6;  end
            2'b01:   begin poly = (W+1)'(11'h11D); m = 4'd8;  end
            default: begin poly = (W+1)'(11'h409); m = 4'd10; end
        endcase
        p = '0;
        for (int i = W - 1; i >= 0; i--) begin
            p = {p[W-1:0], 1'b0};
            if (p[m]) p = p ^ poly;
            if (bb[i]) p = p ^ {1'b0, a};
        end
        return p[W-1:0];
    endfunction

    assign t_q   = (code_q == 2'b10) ? 3'd4 : 3'd2;
    assign start = trig_q & ~trig_q2;

`ifdef KES_EARLY_START_EN
    logic         unused_even;
    logic [W-1:0] sq2, sq4, sq8, sq6;
    assign trig        = kes.i_odd_valid;
    assign unused_even = ^{kes.i_S2, kes.i_S4, kes.i_S6, kes.i_S8, kes.i_all_valid};
    assign sq2 = gf_mul(s[0], s[0], code_q);
    assign sq4 = gf_mul(sq2, sq2, code_q);
    assign sq8 = gf_mul(sq4, sq4, code_q);
    assign sq6 = gf_mul(s[2], s[2], code_q);
`else
    logic unused_odd;
    assign trig       = kes.i_all_valid;
    assign unused_odd = kes.i_odd_valid;
`endif

    // Discrepancy for iteration r: sum Lambda_i * S(2r+1-i), only terms with a real syndrome index.
    logic [W-1:0] delta_c;
    always_comb begin
        delta_c = '0;
        for (int i = 0; i <= T_MAX; i++) begin
            if (i <= 2 * int'(r_q) && i <= int'(t_q))
                delta_c = delta_c ^ gf_mul(lam[i], s[3'(2 * int'(r_q) - i)], code_q);
        end
    end

    // Update step. B carries the x^2 from the skipped even iteration of binary BM.
    logic         upd_b;
    logic [W-1:0] lam_n [0:T_MAX];
    logic [W-1:0] b_n   [0:T_MAX];
    logic [2:0]   l_n;
    always_comb begin
        upd_b    = (delta != '0) && (l_q <= r_q);
        lam_n[0] = gf_mul(gamma, lam[0], code_q);
        for (int i = 1; i <= T_MAX; i++)
            lam_n[i] = gf_mul(gamma, lam[i], code_q) ^ gf_mul(delta, b[i-1], code_q);
        b_n[0] = '0;
        b_n[1] = upd_b ? lam[0] : '0;
        for (int i = 2; i <= T_MAX; i++)
            b_n[i] = upd_b ? lam[i-1] : b[i-2];
        l_n = upd_b ? ({r_q[1:0], 1'b1} - l_q) : l_q;
    end

    logic no_err_c;
    assign no_err_c = ((s[0] | s[1] | s[2] | s[3]) == '0) &&
                      ((t_q == 3'd2) || ((s[4] | s[5] | s[6] | s[7]) == '0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            trig_q        <= 1'b0;
            trig_q2       <= 1'b0;
            code_q        <= 2'b00;
            gamma         <= '0;
            delta         <= '0;
            l_q           <= '0;
            r_q           <= '0;
            for (int i = 0; i < 8; i++) s[i] <= '0;
            for (int i = 0; i <= T_MAX; i++) begin
                lam[i] <= '0;
                b[i]   <= '0;
            end
            kes.o_lambda0 <= '0;
            kes.o_lambda1 <= '0;
            kes.o_lambda2 <= '0;
            kes.o_lambda3 <= '0;
            kes.o_lambda4 <= '0;
            kes.o_deg     <= '0;
            kes.o_valid   <= 1'b0;
            kes.o_busy    <= 1'b0;
            kes.o_fail    <= 1'b0;
            kes.o_no_err  <= 1'b0;
        end else begin
            trig_q      <= trig;
            trig_q2     <= trig_q;
            kes.o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && kes.i_code != 2'b11) begin
                        code_q     <= kes.i_code;
                        s[0]       <= kes.i_S1;
                        s[2]       <= kes.i_S3;
                        s[4]       <= kes.i_S5;
                        s[6]       <= kes.i_S7;
`ifndef KES_EARLY_START_EN
                        s[1]       <= kes.i_S2;
                        s[3]       <= kes.i_S4;
                        s[5]       <= kes.i_S6;
                        s[7]       <= kes.i_S8;
`endif
                        kes.o_busy <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    for (int i = 0; i <= T_MAX; i++) begin
                        lam[i] <= (i == 0) ? W'(1) : '0;
                        b[i]   <= (i == 0) ? W'(1) : '0;
                    end
                    gamma      <= W'(1);
                    l_q        <= '0;
                    r_q        <= '0;
                    kes.o_busy <= 1'b1;
`ifdef KES_EARLY_START_EN
                    s[1]       <= sq2;
                    s[3]       <= sq4;
                    s[5]       <= sq6;
                    s[7]       <= sq8;
`endif
                    state      <= DISC;
                end
                DISC: begin
                    delta <= delta_c;
                    state <= UPD;
                end
                UPD: begin
                    for (int i = 0; i <= T_MAX; i++) begin
                        lam[i] <= lam_n[i];
                        b[i]   <= b_n[i];
                    end
                    if (upd_b) gamma <= delta;
                    l_q   <= l_n;
                    r_q   <= r_q + 3'd1;
                    state <= (r_q + 3'd1 == t_q) ? DONE : DISC;
                end
                DONE: begin
                    kes.o_lambda0 <= lam[0];
                    kes.o_lambda1 <= lam[1];
                    kes.o_lambda2 <= lam[2];
                    kes.o_lambda3 <= (t_q == 3'd4) ? lam[3] : '0;
                    kes.o_lambda4 <= (t_q == 3'd4) ? lam[4] : '0;
                    kes.o_deg     <= l_q;
                    kes.o_fail    <= (l_q > t_q);
                    kes.o_no_err  <= no_err_c;
                    kes.o_valid   <= 1'b1;
                    kes.o_busy    <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
